// File: rtl/sort_drain.sv
// Snapshot-and-stream reader for the systolic insertion sorter.
// Waits for quiet cells, captures them, then emits occupied entries in index order.
module sort_drain #(
    parameter int SORTB      = 8,
    parameter int METAB      = 32,
    parameter int DEPTH      = 8,
    parameter int BEST_FIRST = 1,
    parameter int IW         = $clog2(DEPTH),
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DEPTH-1:0][SORTB-1:0] data_i,
    input  logic [DEPTH-1:0][METAB-1:0] metadata_i,
    input  logic [DEPTH-1:0]            occupied_i,
    input  logic [DEPTH-1:0]            updating_i,
    input  logic                        start_i,
    input  logic                        flush_i,
    output logic [SORTB-1:0]            data_o,
    output logic [METAB-1:0]            metadata_o,
    output logic [IW-1:0]               index_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CW-1:0]               count_o
);

    typedef enum logic [1:0] {IDLE, WAIT_QUIET, STREAM, DONE} state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [DEPTH-1:0][SORTB-1:0] snap_data;
    logic [DEPTH-1:0][METAB-1:0] snap_meta;
    logic [DEPTH-1:0]            pending;
    logic [DEPTH-1:0]            mask_nx;
    logic [IW-1:0]               sel;
    logic                        capture;
    logic                        hs;
    logic                        one_left;

    assign capture = (state == WAIT_QUIET) && (updating_i == '0);
    assign hs      = valid_o && ready_i;
    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);

    // pending holds every not-yet-accepted bit, including the beat on the bus
    always_comb begin
        mask_nx = pending;
        if (capture) begin
            mask_nx = occupied_i;
        end else if (hs) begin
            mask_nx[index_o] = 1'b0;
        end
    end

    always_comb begin
        sel = '0;
        if (BEST_FIRST != 0) begin
            for (int i = 0; i < DEPTH; i++)
                if (mask_nx[i]) sel = IW'(i);
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--)
                if (mask_nx[i]) sel = IW'(i);
        end
    end

    assign one_left = (mask_nx != '0) &&
                      ((mask_nx & (mask_nx - DEPTH'(1))) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:       if (start_i) state_nx = WAIT_QUIET;
                WAIT_QUIET: if (capture)
                                state_nx = (occupied_i != '0) ? STREAM : DONE;
                STREAM:     if (hs && last_o) state_nx = DONE;
                DONE:       state_nx = IDLE;
                default:    state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_data  <= '0;
            snap_meta  <= '0;
            pending    <= '0;
            data_o     <= '0;
            metadata_o <= '0;
            index_o    <= '0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            count_o    <= '0;
        end else if (flush_i) begin
            pending <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end else begin
            if (state == IDLE && start_i) count_o <= '0;
            if (capture) begin
                snap_data <= data_i;
                snap_meta <= metadata_i;
            end
            if (capture || hs) begin
                pending <= mask_nx;
                valid_o <= (mask_nx != '0);
                last_o  <= one_left;
                if (mask_nx != '0) begin
                    index_o    <= sel;
                    data_o     <= capture ? data_i[sel] : snap_data[sel];
                    metadata_o <= capture ? metadata_i[sel] : snap_meta[sel];
                end
            end
            if (hs) count_o <= count_o + CW'(1);
        end
    end

endmodule

// File: tb/tb_sort_drain.sv
// Directed bench for sort_drain: drain order, framing, stalls, quiet wait,
// empty drains, flush and asynchronous reset.
module tb_sort_drain;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0][7:0]  data;
    logic [7:0][31:0] meta;
    logic [7:0]       occupied;
    logic [7:0]       updating;
    logic             start;
    logic             start0;
    logic             flush;
    logic             ready;

    logic [7:0]  data_o, data_o0;
    logic [31:0] meta_o, meta_o0;
    logic [2:0]  index_o, index_o0;
    logic        valid_o, valid_o0;
    logic        last_o, last_o0;
    logic        busy_o, busy_o0;
    logic        done_o, done_o0;
    logic [3:0]  count_o, count_o0;

    int checks = 0;
    int failures = 0;
    int e;
    int sp [3] = '{2, 5, 7};

    always #5 clk = ~clk;

    sort_drain #(.BEST_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data), .metadata_i(meta),
        .occupied_i(occupied), .updating_i(updating), .start_i(start),
        .flush_i(flush), .data_o(data_o), .metadata_o(meta_o),
        .index_o(index_o), .valid_o(valid_o), .ready_i(ready),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o),
        .count_o(count_o)
    );

    sort_drain #(.BEST_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_i(data), .metadata_i(meta),
        .occupied_i(occupied), .updating_i(updating), .start_i(start0),
        .flush_i(flush), .data_o(data_o0), .metadata_o(meta_o0),
        .index_o(index_o0), .valid_o(valid_o0), .ready_i(ready),
        .last_o(last_o0), .busy_o(busy_o0), .done_o(done_o0),
        .count_o(count_o0)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data[i] = 8'(10 + i);
            meta[i] = 32'hA000_0000 + i;
        end
        occupied = 8'hFF;
        updating = 8'h00;
        start = 1'b0;
        start0 = 1'b0;
        flush = 1'b0;
        ready = 1'b1;
        #12;
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_data", data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // full drain, best first
        pulse_start();
        chk("t1_busy", busy_o, 1);
        chk("t1_novalid", valid_o, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("t1_valid", valid_o, 1);
            chk("t1_data", data_o, 17 - k);
            chk("t1_index", index_o, 7 - k);
            chk("t1_meta", meta_o, 32'hA000_0007 - k);
            chk("t1_last", last_o, k == 7);
            tick();
        end
        chk("t1_done", done_o, 1);
        chk("t1_valid_off", valid_o, 0);
        chk("t1_count", count_o, 8);
        chk("t1_busy_done", busy_o, 1);
        tick();
        chk("t1_done_off", done_o, 0);
        chk("t1_idle", busy_o, 0);

        // sparse mask, worst first
        occupied = 8'b1010_0100;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t2_valid", valid_o0, 1);
            chk("t2_index", index_o0, sp[k]);
            chk("t2_data", data_o0, 10 + sp[k]);
            chk("t2_last", last_o0, k == 2);
            tick();
        end
        chk("t2_done", done_o0, 1);
        chk("t2_count", count_o0, 3);
        tick();
        occupied = 8'hFF;

        // backpressure 1,0,0,1
        pulse_start();
        tick();
        e = 7;
        for (int c = 0; c < 40 && e >= 0; c++) begin
            ready = (c % 4 == 0) || (c % 4 == 3);
            chk("t3_valid", valid_o, 1);
            chk("t3_index", index_o, e);
            chk("t3_data", data_o, 10 + e);
            chk("t3_last", last_o, e == 0);
            tick();
            if (ready) e--;
        end
        ready = 1'b1;
        chk("t3_all", e, -1);
        chk("t3_done", done_o, 1);
        chk("t3_count", count_o, 8);
        tick();

        // quiescence wait
        updating = 8'h04;
        data[7] = 8'd99;
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            chk("t4_wait", valid_o, 0);
            tick();
        end
        updating = 8'h00;
        data[7] = 8'd55;
        chk("t4_wait_last", valid_o, 0);
        tick();
        chk("t4_valid", valid_o, 1);
        chk("t4_data_q", data_o, 55);
        chk("t4_index", index_o, 7);
        data[6] = 8'd77;
        updating = 8'h04;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t4_data", data_o, 17 - k);
            chk("t4_index_k", index_o, 7 - k);
        end
        tick();
        chk("t4_done", done_o, 1);
        tick();
        data[7] = 8'd17;
        data[6] = 8'd16;
        updating = 8'h00;

        // empty drain
        occupied = 8'h00;
        pulse_start();
        chk("t5_busy", busy_o, 1);
        chk("t5_nodone", done_o, 0);
        tick();
        chk("t5_done", done_o, 1);
        chk("t5_valid", valid_o, 0);
        chk("t5_count", count_o, 0);
        tick();
        chk("t5_idle", busy_o, 0);
        occupied = 8'hFF;

        // start mid-stream is ignored
        pulse_start();
        tick();
        chk("t6_first", index_o, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_second", index_o, 6);
        for (int idx = 5; idx >= 0; idx--) begin
            tick();
            chk("t6_index", index_o, idx);
        end
        tick();
        chk("t6_done", done_o, 1);
        chk("t6_count", count_o, 8);
        tick();
        chk("t6_idle", busy_o, 0);

        // flush after three beats
        pulse_start();
        tick();
        tick();
        tick();
        tick();
        chk("t7_pre_count", count_o, 3);
        chk("t7_pre_index", index_o, 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t7_valid", valid_o, 0);
        chk("t7_last", last_o, 0);
        chk("t7_busy", busy_o, 0);
        chk("t7_done", done_o, 0);
        chk("t7_count", count_o, 3);
        tick();
        chk("t7_nodone", done_o, 0);
        chk("t7_count_hold", count_o, 3);

        // reset mid-stream
        pulse_start();
        tick();
        tick();
        chk("t8_streaming", valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t8_valid", valid_o, 0);
        chk("t8_data", data_o, 0);
        chk("t8_meta", meta_o, 0);
        chk("t8_index", index_o, 0);
        chk("t8_last", last_o, 0);
        chk("t8_busy", busy_o, 0);
        chk("t8_done", done_o, 0);
        chk("t8_count", count_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_start();
        tick();
        for (int idx = 7; idx >= 0; idx--) begin
            chk("t8_re_index", index_o, idx);
            tick();
        end
        chk("t8_re_done", done_o, 1);
        chk("t8_re_count", count_o, 8);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_drain.md
# sort_drain

Read-side companion to the systolic insertion sorter: waits for the sorter's cell array to go quiescent, captures a snapshot of all occupied cells, then streams the entries one per handshake, best-first or worst-first, over a valid/ready interface. It sits between the sorter's parallel outputs and any serial consumer, such as a readout FIFO or link packer. Unoccupied cells are skipped, and the stream is framed with `last_o` and a `done_o` pulse.

## Interface
- `SORTB`, 8, sort-key width
- `METAB`, 32, metadata width
- `DEPTH`, 8, number of sorter cells; index DEPTH-1 holds the best entry
- `BEST_FIRST`, 1: 1 streams from index DEPTH-1 downward; 0 streams from index 0 upward
- `IW`, $clog2(DEPTH), index width (derived)
- `CW`, $clog2(DEPTH+1), count width (derived)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `data_i`  in  SORTB x DEPTH  sorter key array
- `metadata_i`  in  METAB x DEPTH  sorter metadata array
- `occupied_i`  in  DEPTH  per-cell occupancy mask
- `updating_i`  in  DEPTH  per-cell update-in-progress flags from the sorter
- `start_i`  in  1  request a drain; single-cycle pulse
- `flush_i`  in  1  abort the current drain
- `data_o`  out  SORTB  streamed key
- `metadata_o`  out  METAB  streamed metadata
- `index_o`  out  IW  source cell index of the current beat
- `valid_o`  out  1  beat valid
- `ready_i`  in  1  consumer ready
- `last_o`  out  1  final beat of this drain, qualified by `valid_o`
- `busy_o`  out  1  high in any state other than IDLE
- `done_o`  out  1  one-cycle pulse at the end of a drain
- `count_o`  out  CW  beats accepted in the current or last drain

## Operation
- **FSM states:** IDLE, WAIT_QUIET, STREAM, DONE.
- **IDLE:**
  - `start_i` moves to WAIT_QUIET.
  - `count_o` clears to 0 on the same edge.
- **WAIT_QUIET:**
  - On the first cycle with `updating_i == 0`, capture `data_i`, `metadata_i` and `occupied_i` into snapshot registers.
  - If the captured mask is nonzero, go to STREAM; if zero, go to DONE.
  - The live inputs are ignored after capture.
- **STREAM:**
  - A pending mask (copy of the snapshot mask) and a combinational priority encoder select the next set bit: highest index if BEST_FIRST=1, lowest if 0.
  - Outputs are registered from that selection. While `valid_o` is high, the outputs are held stable until the handshake.
  - On a handshake (`valid_o & ready_i`): clear the selected bit, increment `count_o`, and present the next entry on the following cycle with no bubble.
  - `last_o` is high when exactly one pending bit remains.
  - A handshake with `last_o` high goes to DONE.
- **DONE:** `done_o` is high for one cycle, then return to IDLE.
- `start_i` while busy is ignored.
- **`flush_i`:**
  - Has priority over everything else.
  - In any state it returns to IDLE next cycle and drops `valid_o`/`last_o`.
  - Clears the pending mask, does not pulse `done_o`, and holds `count_o`.
- **Ties:** equal keys need no special handling; index order alone defines the stream order.
- **Reset values:** asserting `rst_n` low forces IDLE immediately, mid-drain included. Every output resets to 0: `data_o`, `metadata_o`, `index_o`, `valid_o`, `last_o`, `busy_o`, `done_o`, `count_o`.

## Timing
- The `start_i` edge enters WAIT_QUIET.
- The capture edge is the first edge at which `updating_i == 0` is seen in WAIT_QUIET. With the sorter already quiet, capture is 1 cycle after start.
- `valid_o` rises on the cycle after the capture edge, so the minimum start-to-first-valid is 2 cycles.
- Throughput: 1 beat/cycle while `ready_i` is held high.
- `done_o` asserts the cycle after the last handshake, or the cycle after capture when the mask is empty.
- `busy_o` is high from the cycle after `start_i` through the `done_o` cycle inclusive.
- Back-to-back drains: the earliest `start_i` is the cycle after `done_o`, when the block is in IDLE.

## Test plan
- **Full drain, best first:** DEPTH=8, BEST_FIRST=1, all cells occupied, keys 10..17 at index 0..7, `ready_i`=1, start.
  - 8 beats with keys 17,16,…,10 and `index_o` 7..0.
  - `last_o` only on key 10; `done_o` 1 cycle later; `count_o`=8.
- **Sparse mask, BEST_FIRST=0:** `occupied_i`=8'b1010_0100 → beats at index 2, 5, 7 in that order; `last_o` on index 7; `count_o`=3.
- **Backpressure:** toggle `ready_i` 1,0,0,1,… → outputs held stable while stalled, no lost or duplicated beats, order unchanged.
- **Quiescence wait:** `updating_i`=8'h04 for 5 cycles after start, then 0.
  - Snapshot reflects the inputs at the first quiet cycle; values changed earlier are not captured.
  - `valid_o` rises 1 cycle after that quiet cycle.
- **Empty and ignored start:**
  - `occupied_i`=0 → no `valid_o`; `done_o` 2 cycles after start; `count_o`=0.
  - `start_i` pulsed mid-stream → ignored.
- **Flush and reset mid-drain:**
  - `flush_i` after 3 beats → IDLE next cycle, `valid_o`=0, no `done_o`, `count_o`=3.
  - `rst_n` low during STREAM → all outputs 0 immediately.
  - After `rst_n` releases, a new drain completes normally.
